id_ex_stage: RTL

ID/EX pipeline stage directly upstream of the ALU. Registers decoded operands and control from ID and forwards from EX/MEM and MEM/WB. Presents final `data1`/`data2`/`ALUCtrl` to the ALU in the EX cycle. Detects load-use (or, without forwarding, all RAW) hazards and drives `stall_o` to freeze PC and IF/ID while inserting bubbles.

---
 rtl/id_ex_stage_if.sv | 57 +++++
 rtl/id_ex_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded instruction from ID, writeback candidates from
// EX/MEM and MEM/WB, and the ALU operands and control handed to EX.
// master = upstream pipeline side, slave = the ID/EX stage itself.
interface id_ex_stage_if;
    logic        valid_i;
    logic        flush_i;
    logic [31:0] RSdata_i;
    logic [31:0] RTdata_i;
    logic [31:0] imm_i;
    logic [4:0]  RSaddr_i;
    logic [4:0]  RTaddr_i;
    logic [4:0]  RDaddr_i;
    logic        ALUSrc_i;
    logic        RegWrite_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic        MemtoReg_i;
    logic [2:0]  ALUCtrl_i;
    logic        EXMEM_RegWrite_i;
    logic [4:0]  EXMEM_RDaddr_i;
    logic [31:0] EXMEM_data_i;
    logic        MEMWB_RegWrite_i;
    logic [4:0]  MEMWB_RDaddr_i;
    logic [31:0] MEMWB_data_i;

    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic [2:0]  ALUCtrl_o;
    logic [31:0] RTdata_o;
    logic [4:0]  RDaddr_o;
    logic        RegWrite_o;
    logic        MemRead_o;
    logic        MemWrite_o;
    logic        MemtoReg_o;
    logic        valid_o;
    logic        stall_o;

    modport slave (
        input  valid_i, flush_i, RSdata_i, RTdata_i, imm_i,
               RSaddr_i, RTaddr_i, RDaddr_i,
               ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUCtrl_i,
               EXMEM_RegWrite_i, EXMEM_RDaddr_i, EXMEM_data_i,
               MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_data_i,
        output data1_o, data2_o, ALUCtrl_o, RTdata_o, RDaddr_o,
               RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, valid_o, stall_o
    );

    modport master (
        output valid_i, flush_i, RSdata_i, RTdata_i, imm_i,
               RSaddr_i, RTaddr_i, RDaddr_i,
               ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUCtrl_i,
               EXMEM_RegWrite_i, EXMEM_RDaddr_i, EXMEM_data_i,
               MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_data_i,
        input  data1_o, data2_o, ALUCtrl_o, RTdata_o, RDaddr_o,
               RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, valid_o, stall_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
// Optional feature macro: ID_EX_FORWARD_EN
//   defined   : EX/MEM > MEM/WB operand forwarding, stall on load-use only
//   undefined : no forwarding, stall on any RAW against EX or EX/MEM
module id_ex_stage (
    input  logic           clk_i,
    input  logic           rst_i,
    id_ex_stage_if.slave   bus
);
    logic        valid_q, regwrite_q, memread_q, memwrite_q, memtoreg_q, alusrc_q;
    logic [2:0]  aluctrl_q;
    logic [4:0]  rd_q, rs_q, rt_q;
    logic [31:0] rsdata_q, rtdata_q, imm_q;
    logic [31:0] rs_val, rt_val;
    logic        stall, capture, rt_used;

    // RT only matters as a source when it feeds the ALU or is store data.
    assign rt_used = ~bus.ALUSrc_i | bus.MemWrite_i;
    assign capture = bus.valid_i & ~stall & ~bus.flush_i;

    // Stage register: capture ID or load a bubble (control cleared, data held).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluctrl_q  <= 3'd0;
            rd_q       <= 5'd0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            rsdata_q   <= 32'd0;
            rtdata_q   <= 32'd0;
            imm_q      <= 32'd0;
        end else if (capture) begin
            valid_q    <= 1'b1;
            regwrite_q <= bus.RegWrite_i;
            memread_q  <= bus.MemRead_i;
            memwrite_q <= bus.MemWrite_i;
            memtoreg_q <= bus.MemtoReg_i;
            alusrc_q   <= bus.ALUSrc_i;
            aluctrl_q  <= bus.ALUCtrl_i;
            rd_q       <= bus.RDaddr_i;
            rs_q       <= bus.RSaddr_i;
            rt_q       <= bus.RTaddr_i;
            rsdata_q   <= bus.RSdata_i;
            rtdata_q   <= bus.RTdata_i;
            imm_q      <= bus.imm_i;
        end else begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end
    end

`ifdef ID_EX_FORWARD_EN
    // Youngest producer wins; r0 is hardwired and never forwarded.
    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d,
                                        input logic xwe, input logic [4:0] xrd,
                                        input logic [31:0] xd, input logic wwe,
                                        input logic [4:0] wrd, input logic [31:0] wd);
        logic [31:0] r;
        r = d;
        if (xwe && xrd != 5'd0 && xrd == a)      r = xd;
        else if (wwe && wrd != 5'd0 && wrd == a) r = wd;
        return r;
    endfunction

    // Operand forwarding from EX/MEM and MEM/WB.
    always_comb begin
        rs_val = fwd(rs_q, rsdata_q, bus.EXMEM_RegWrite_i, bus.EXMEM_RDaddr_i,
                     bus.EXMEM_data_i, bus.MEMWB_RegWrite_i, bus.MEMWB_RDaddr_i,
                     bus.MEMWB_data_i);
        rt_val = fwd(rt_q, rtdata_q, bus.EXMEM_RegWrite_i, bus.EXMEM_RDaddr_i,
                     bus.EXMEM_data_i, bus.MEMWB_RegWrite_i, bus.MEMWB_RDaddr_i,
                     bus.MEMWB_data_i);
    end

    // Load-use: the loaded value is not available until MEM/WB.
    always_comb begin
        stall = 1'b0;
        if (bus.valid_i && valid_q && memread_q && rd_q != 5'd0 &&
            (rd_q == bus.RSaddr_i || (rd_q == bus.RTaddr_i && rt_used)))
            stall = 1'b1;
    end
`else
    logic unused_nofwd;
    assign unused_nofwd = ^{bus.EXMEM_data_i, bus.MEMWB_RegWrite_i, bus.MEMWB_RDaddr_i,
                            bus.MEMWB_data_i, rs_q, rt_q};

    // Without forwarding operands are the values read in ID.
    always_comb begin
        rs_val = rsdata_q;
        rt_val = rtdata_q;
    end

    // Any RAW against EX or EX/MEM must wait until the producer reaches MEM/WB,
    // where the register file's write-before-read covers it.
    always_comb begin
        logic ex_hit, mem_hit;
        ex_hit  = valid_q && regwrite_q && rd_q != 5'd0 &&
                  (rd_q == bus.RSaddr_i || (rd_q == bus.RTaddr_i && rt_used));
        mem_hit = bus.EXMEM_RegWrite_i && bus.EXMEM_RDaddr_i != 5'd0 &&
                  (bus.EXMEM_RDaddr_i == bus.RSaddr_i ||
                   (bus.EXMEM_RDaddr_i == bus.RTaddr_i && rt_used));
        stall   = bus.valid_i && (ex_hit || mem_hit);
    end
`endif

    assign bus.data1_o    = rs_val;
    assign bus.RTdata_o   = rt_val;
    assign bus.data2_o    = alusrc_q ? imm_q : rt_val;
    assign bus.ALUCtrl_o  = aluctrl_q;
    assign bus.RDaddr_o   = rd_q;
    assign bus.RegWrite_o = regwrite_q;
    assign bus.MemRead_o  = memread_q;
    assign bus.MemWrite_o = memwrite_q;
    assign bus.MemtoReg_o = memtoreg_q;
    assign bus.valid_o    = valid_q;
    assign bus.stall_o    = stall;
endmodule
